// File: rtl/dem_tree_scheduler.sv
// Sequencer for the tree-structured DEM encoder: walks 2^LEVELS-1 nodes through one shared switching node.
// Optional DEM_SCHED_CHECK_EN builds a per-job consistency checker driving err_o.
module dem_tree_scheduler #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned LEVELS = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           code_i,
  output logic                       sw_req_o,
  input  logic                       sw_ack_i,
  output logic [WIDTH-1:0]           sw_x_o,
  output logic [$clog2(LEVELS):0]    sw_level_o,
  output logic [LEVELS-2:0]          sw_index_o,
  input  logic [WIDTH-1:0]           sw_out1_i,
  input  logic [WIDTH-1:0]           sw_out2_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [(1<<LEVELS)-1:0]     elem_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned N  = 1 << LEVELS;
  localparam int unsigned NB = N / 2;
  localparam int unsigned IW = LEVELS - 1;
  localparam int unsigned LW = $clog2(LEVELS) + 1;
  localparam int unsigned SW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] node_q [2][NB];
  logic             cur_q;
  logic [IW-1:0]    last_q;
  logic [N-1:0]     elem_q;

  logic [WIDTH-1:0] code_sat_c;
  logic             leaf_c;
  logic             level_end_c;
  logic [IW-1:0]    slot_c;
  logic [IW-1:0]    next_idx_c;

  assign code_sat_c  = (code_i > WIDTH'(N)) ? WIDTH'(N) : code_i;
  assign leaf_c      = (sw_level_o == LW'(1));
  assign level_end_c = (sw_index_o == last_q);
  assign slot_c      = IW'({sw_index_o, 1'b0});
  assign next_idx_c  = sw_index_o + IW'(1);

  // last_q tracks the final index of the current level (0, 1, 3, 7, ...)
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      in_ready_o  <= 1'b1;
      sw_req_o    <= 1'b0;
      sw_x_o      <= '0;
      sw_level_o  <= '0;
      sw_index_o  <= '0;
      out_valid_o <= 1'b0;
      elem_o      <= '0;
      busy_o      <= 1'b0;
      cur_q       <= 1'b0;
      last_q      <= '0;
      elem_q      <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(NB); i++) begin
          node_q[b][i] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q           <= ISSUE;
            in_ready_o        <= 1'b0;
            busy_o            <= 1'b1;
            sw_req_o          <= 1'b1;
            sw_x_o            <= code_sat_c;
            sw_level_o        <= LW'(LEVELS);
            sw_index_o        <= '0;
            last_q            <= '0;
            node_q[cur_q][0]  <= code_sat_c;
          end
        end
        ISSUE: begin
          if (sw_ack_i) begin
            if (leaf_c) begin
              elem_q[{sw_index_o, 1'b0}] <= sw_out1_i[0];
              elem_q[{sw_index_o, 1'b1}] <= sw_out2_i[0];
            end else begin
              node_q[~cur_q][slot_c]          <= sw_out1_i;
              node_q[~cur_q][slot_c | IW'(1)] <= sw_out2_i;
            end
            if (level_end_c) begin
              if (leaf_c) begin
                state_q  <= DONE;
                sw_req_o <= 1'b0;
              end else begin
                sw_level_o <= sw_level_o - LW'(1);
                sw_index_o <= '0;
                last_q     <= IW'({last_q, 1'b1});
                cur_q      <= ~cur_q;
                // Slot 0 of the next level is being written this cycle when the level had one node
                sw_x_o     <= (sw_index_o == '0) ? sw_out1_i : node_q[~cur_q][0];
              end
            end else begin
              sw_index_o <= next_idx_c;
              sw_x_o     <= node_q[cur_q][next_idx_c];
            end
          end
        end
        DONE: begin
          if (!out_valid_o) begin
            out_valid_o <= 1'b1;
            elem_o      <= elem_q;
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_q     <= IDLE;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DEM_SCHED_CHECK_EN
  logic [SW-1:0] sum_c;
  logic [SW-1:0] lim_c;

  assign sum_c = {1'b0, sw_out1_i} + {1'b0, sw_out2_i};
  assign lim_c = SW'(1) << (sw_level_o - LW'(1));

  // Sticky flag: children must conserve the parent value and fit the subtree
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_o <= 1'b0;
    end else if (state_q == ISSUE && sw_ack_i &&
                 (sum_c != {1'b0, sw_x_o} ||
                  {1'b0, sw_out1_i} > lim_c ||
                  {1'b0, sw_out2_i} > lim_c)) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dem_tree_scheduler.sv
// Self-checking bench for dem_tree_scheduler: vector table, scoreboard queue and a behavioural node model.
module tb_dem_tree_scheduler;

  localparam int unsigned WIDTH  = 5;
  localparam int unsigned LEVELS = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  code_i;
  logic        sw_req_o;
  logic        sw_ack_i;
  logic [4:0]  sw_x_o;
  logic [2:0]  sw_level_o;
  logic [2:0]  sw_index_o;
  logic [4:0]  sw_out1_i;
  logic [4:0]  sw_out2_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] elem_o;
  logic        busy_o;
  logic        err_o;

  dem_tree_scheduler #(.WIDTH(WIDTH), .LEVELS(LEVELS)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .code_i(code_i),
    .sw_req_o(sw_req_o), .sw_ack_i(sw_ack_i), .sw_x_o(sw_x_o),
    .sw_level_o(sw_level_o), .sw_index_o(sw_index_o),
    .sw_out1_i(sw_out1_i), .sw_out2_i(sw_out2_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .elem_o(elem_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  code;
    int          mode;   // 0 floor/ceil, 1 random valid, 2 faulty at x=5
    int          delay;
    int          hold;
    bit          exact;
    logic [15:0] elem;
    int          pop;
  } vec_t;

  typedef struct {
    bit          exact;
    logic [15:0] elem;
    int          pop;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  int n_cmp = 0;
  int n_fail = 0;
  int mode = 0;
  int ack_delay = 0;
  int job_cnt = 0;
  int wait_cnt = 0;
  bit stray = 1'b0;
  logic [4:0] exp_root;
  logic [4:0] lx;
  logic [2:0] llev;
  logic [2:0] lidx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Node model: acks after ack_delay wait cycles, checks job order and held request fields
  initial begin
    sw_ack_i = 1'b0; sw_out1_i = '0; sw_out2_i = '0;
    forever begin
      @(negedge clk_i);
      if (sw_req_o) begin
        if (wait_cnt == 0) begin
          lx = sw_x_o; llev = sw_level_o; lidx = sw_index_o;
        end else begin
          chk("hold_x", sw_x_o, lx);
          chk("hold_level", sw_level_o, llev);
          chk("hold_index", sw_index_o, lidx);
        end
        if (wait_cnt >= ack_delay) begin
          int k, p, lim, lo, hi, o1;
          k = job_cnt + 1; p = 0;
          while (k > 1) begin k = k >> 1; p++; end
          chk("order_level", sw_level_o, LEVELS - p);
          chk("order_index", sw_index_o, job_cnt + 1 - (1 << p));
          if (job_cnt == 0) chk("root_x", sw_x_o, exp_root);
          lim = 1 << (int'(sw_level_o) - 1);
          if (mode == 1) begin
            lo = (int'(sw_x_o) > lim) ? int'(sw_x_o) - lim : 0;
            hi = (int'(sw_x_o) < lim) ? int'(sw_x_o) : lim;
            o1 = int'($urandom_range(hi, lo));
          end else begin
            o1 = int'(sw_x_o) / 2;
          end
          if (mode == 2 && sw_x_o == 5'd5) begin
            sw_out1_i = 5'd3; sw_out2_i = 5'd3;
          end else begin
            sw_out1_i = 5'(o1); sw_out2_i = 5'(int'(sw_x_o) - o1);
          end
          sw_ack_i = 1'b1;
          job_cnt++;
          wait_cnt = 0;
        end else begin
          sw_ack_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        sw_ack_i = stray;
        sw_out1_i = 5'd1; sw_out2_i = 5'd1;
        wait_cnt = 0;
      end
    end
  end

  task automatic run_sample(input vec_t v);
    int lat;
    exp_t e;
    logic [15:0] held;
    mode = v.mode; ack_delay = v.delay; job_cnt = 0;
    exp_root = (v.code > 5'd16) ? 5'd16 : v.code;
    e.exact = v.exact; e.elem = v.elem; e.pop = v.pop;
    sb.push_back(e);
    @(negedge clk_i);
    chk("in_ready_idle", in_ready_o, 1);
    code_i = v.code; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    chk("busy_after_accept", busy_o, 1);
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!out_valid_o && lat < 400);
    chk("latency", lat, 1 + 15 * (v.delay + 1));
    chk("job_count", job_cnt, 15);
    e = sb.pop_front();
    if (e.exact) chk("elem", elem_o, e.elem);
    chk("popcount", $countones(elem_o), e.pop);
    held = elem_o;
    for (int i = 0; i < v.hold; i++) begin
      code_i = 5'd3; in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      chk("done_elem_stable", elem_o, held);
      chk("done_in_ready", in_ready_o, 0);
      chk("done_valid", out_valid_o, 1);
      chk("done_no_req", sw_req_o, 0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    chk("post_hs_valid", out_valid_o, 0);
    chk("post_hs_in_ready", in_ready_o, 1);
    chk("post_hs_busy", busy_o, 0);
    chk("post_hs_elem_held", elem_o, held);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_sw_req", sw_req_o, 0);
    chk("rst_sw_x", sw_x_o, 0);
    chk("rst_sw_level", sw_level_o, 0);
    chk("rst_sw_index", sw_index_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_elem", elem_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
  endtask

  initial begin
    vec_t bad;
    vecs[0] = '{code: 5'd0,  mode: 0, delay: 0, hold: 0, exact: 1, elem: 16'h0000, pop: 0};
    vecs[1] = '{code: 5'd16, mode: 0, delay: 0, hold: 0, exact: 1, elem: 16'hFFFF, pop: 16};
    vecs[2] = '{code: 5'd7,  mode: 1, delay: 0, hold: 0, exact: 0, elem: 16'h0000, pop: 7};
    vecs[3] = '{code: 5'd7,  mode: 0, delay: 3, hold: 0, exact: 1, elem: 16'hAAA8, pop: 7};
    vecs[4] = '{code: 5'd20, mode: 0, delay: 0, hold: 5, exact: 1, elem: 16'hFFFF, pop: 16};
    vecs[5] = '{code: 5'd9,  mode: 1, delay: 1, hold: 0, exact: 0, elem: 16'h0000, pop: 9};
    vecs[6] = '{code: 5'd1,  mode: 0, delay: 0, hold: 2, exact: 1, elem: 16'h8000, pop: 1};
    bad     = '{code: 5'd5,  mode: 2, delay: 0, hold: 0, exact: 0, elem: 16'h0000, pop: 6};

    reset_i = 1'b1; in_valid_i = 1'b0; code_i = '0; out_ready_i = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    foreach (vecs[i]) run_sample(vecs[i]);

    // Stray acks while idle must not start anything
    @(negedge clk_i);
    stray = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("stray_idle_req", sw_req_o, 0);
      chk("stray_idle_ready", in_ready_o, 1);
    end
    stray = 1'b0;

    // Reset in the middle of a slow job
    mode = 0; ack_delay = 3; job_cnt = 0; exp_root = 5'd9;
    @(negedge clk_i);
    code_i = 5'd9; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    chk("mid_req_before_rst", sw_req_o, 1);
    reset_i = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk_i);
    reset_i = 1'b0;
    stray = 1'b1;
    repeat (2) begin
      @(posedge clk_i); #1;
      chk("late_ack_req", sw_req_o, 0);
      chk("late_ack_busy", busy_o, 0);
    end
    stray = 1'b0;
    run_sample(vecs[1]);

    // Inconsistent node result: 5 -> 3,3
    chk("err_before_bad", err_o, 0);
    run_sample(bad);
`ifdef DEM_SCHED_CHECK_EN
    chk("err_after_bad", err_o, 1);
`else
    chk("err_after_bad", err_o, 0);
`endif
    repeat (3) @(posedge clk_i);
    #1;
`ifdef DEM_SCHED_CHECK_EN
    chk("err_sticky", err_o, 1);
`else
    chk("err_sticky", err_o, 0);
`endif
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    chk("err_cleared", err_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dem_tree_scheduler.md
Name: dem_tree_scheduler

Overview:
Sequencer for the tree-structured DEM encoder. A single shared switching-node datapath is time-multiplexed across all 2^LEVELS-1 tree nodes. Per accepted quantizer code, the block walks the tree root-to-leaves, issues one node job per request/ack handshake, buffers the child values between levels, and emits the final unit-element select vector to the DAC array.

Parameters:
WIDTH, 5, width of code and node values; must satisfy WIDTH >= LEVELS+1
LEVELS, 4, tree depth; number of unit elements N = 2^LEVELS; LEVELS >= 2

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
in_valid_i  in  1  input code valid
in_ready_o  out  1  block can accept a code
code_i  in  WIDTH  quantizer code, legal range 0..N
sw_req_o  out  1  node job request to shared switching node
sw_ack_i  in  1  node job complete; children valid this cycle
sw_x_o  out  WIDTH  node input value x_n,r
sw_level_o  out  $clog2(LEVELS)+1  node level n (LEVELS = root, 1 = leaf parent)
sw_index_o  out  LEVELS-1  node index r within level
sw_out1_i  in  WIDTH  child value x_n-1,2r
sw_out2_i  in  WIDTH  child value x_n-1,2r+1
out_valid_o  out  1  element vector valid
out_ready_i  in  1  downstream accepts vector
elem_o  out  N  unit-element selects; bit k drives element k
busy_o  out  1  high in any state except IDLE
err_o  out  1  sticky consistency error (see Optional Feature)

Behaviour:
- Reset values: in_ready_o=1, sw_req_o=0, sw_x_o=0, sw_level_o=0, sw_index_o=0, out_valid_o=0, elem_o=0, busy_o=0, err_o=0. FSM=IDLE. Node buffers cleared.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: in_ready_o=1. When in_valid_i is high, the code is accepted. A code greater than N saturates to N. The value is stored as the root, the level counter is set to LEVELS and the index to 0. Next state is ISSUE.
- ISSUE: sw_req_o=1. sw_x_o, sw_level_o and sw_index_o come from the current-level buffer and are held stable until the ack.
- A job completes in the cycle where sw_req_o && sw_ack_i. An ack in the first request cycle is legal, giving a minimum of 1 cycle per node. sw_ack_i while sw_req_o=0 is ignored.
- On completion, sw_out1_i is written to next-level slot 2r and sw_out2_i to slot 2r+1.
- After completion the index increments. When the index reaches 2^(LEVELS-level)-1, the level decrements, the index resets to 0 and the buffers swap (ping-pong).
- Node order: level-major from the root down, index ascending within a level. Total of N-1 jobs per sample.
- At level 1, the child LSBs are written directly into elem_o[2r] and elem_o[2r+1]; upper bits are ignored.
- The ack of the last job (level 1, r=N/2-1) moves the FSM to DONE. out_valid_o=1 on the next cycle.
- Minimum latency from the accept cycle to out_valid_o is N cycles (16 at the defaults).
- DONE: sw_req_o=0. elem_o and out_valid_o are held until out_ready_i is high. That handshake clears out_valid_o and returns to IDLE. in_ready_o goes high the following cycle; there is no back-to-back accept in DONE.
- elem_o holds its last value after the handshake until the next DONE update.
- in_valid_i is ignored outside IDLE, and code_i is not sampled there.
- Reset mid-job immediately drops sw_req_o and abandons the sample. A late sw_ack_i after reset is ignored.

Optional Feature:
- Macro: DEM_SCHED_CHECK_EN.
- When defined, every completed job is checked for:
  - sw_out1_i + sw_out2_i == sw_x_o (sum computed at WIDTH+1 bits);
  - each child <= 2^(level-1).
- Any violation sets err_o on the next cycle. err_o stays set until reset. The offending values are still stored and the sequence continues.
- When undefined, err_o is tied to 0 and no check logic is built.

Test Plan:
- Always-ack node model (children = floor/ceil split), code_i=0 → 15 jobs on consecutive cycles; out_valid_o 16 cycles after accept; elem_o=16'h0000.
- code_i=16 → elem_o=16'hFFFF. Root job sees sw_x_o=16, sw_level_o=4, sw_index_o=0.
- code_i=7 with a random valid split model → popcount(elem_o)=7; job order checked as (4,0),(3,0),(3,1),(2,0..3),(1,0..7).
- sw_ack_i delayed 3 cycles on each job → sw_req_o and sw_x/level/index stay stable during the wait; latency is 1+15*4 cycles; stray ack with req=0 has no effect.
- out_ready_i held low 5 cycles in DONE → elem_o stable, in_ready_o=0, new in_valid_i ignored; release → IDLE next cycle. code_i=20 → saturates, elem_o=16'hFFFF.
- DEM_SCHED_CHECK_EN: model returns children 3,3 for x=5 → err_o=1 next cycle and stays set; reset clears it. Reset asserted mid-ISSUE → all outputs return to reset values.
